// File: rtl/mod_step_counter_pkg.sv
// Shared types for the modulo-N step counter: counting modes and control FSM states.
package mod_step_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The reserved encoding counts exactly like WRAP.
    function automatic logic is_wrap_mode(input mode_e m);
        return (m == MODE_WRAP) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/mod_step_next.sv
// Combinational next-count datapath: one step up or down with wrap or clamp at the range ends.
module mod_step_next
    import mod_step_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    input  mode_e             mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              wrap_hit,
    output logic              term_hit
);

    localparam int unsigned    AW   = WIDTH + 2;
    localparam logic [AW-1:0]  MAXV = AW'(MAX_VAL);
    localparam logic [AW-1:0]  MODV = AW'(MAX_VAL) + AW'(1);

    logic [AW-1:0] c_ext;
    logic [AW-1:0] s_ext;
    logic [AW-1:0] sum;
    logic [AW-1:0] res;

    always_comb begin
        c_ext    = AW'(count);
        s_ext    = AW'(step);
        sum      = c_ext + s_ext;
        res      = c_ext;
        wrap_hit = 1'b0;
        if (!dir) begin
            if (sum > MAXV) begin
                if (is_wrap_mode(mode)) begin
                    res      = sum - MODV;
                    wrap_hit = 1'b1;
                end else begin
                    res = MAXV;
                end
            end else begin
                res = sum;
            end
        end else begin
            if (s_ext > c_ext) begin
                if (is_wrap_mode(mode)) begin
                    res      = c_ext + MODV - s_ext;
                    wrap_hit = 1'b1;
                end else begin
                    res = '0;
                end
            end else begin
                res = c_ext - s_ext;
            end
        end
        next_count = res[WIDTH-1:0];
        term_hit   = dir ? (res == '0) : (res == MAXV);
    end

endmodule

// File: rtl/mod_step_counter.sv
// Modulo-N up/down step counter with wrap/saturate/one-shot modes, parallel load and run control.
module mod_step_counter
    import mod_step_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic              clk,
    input  logic              a_rst_n,
    input  logic              reset,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              start,
    input  logic              stop,
    output logic [WIDTH-1:0]  count,
    output logic              wrap,
    output logic              sat,
    output logic              done,
    output logic              busy
);

    if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $fatal(1, "mod_step_counter: MAX_VAL does not fit in WIDTH bits");
    end
    if (RST_VAL > MAX_VAL) begin : g_bad_rst
        $fatal(1, "mod_step_counter: RST_VAL exceeds MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RSTC = WIDTH'(RST_VAL);

    mode_e            mode_m;
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] count_d;
    logic             wrap_hit;
    logic             term_hit;
    logic             wrap_d;
    logic             sat_d;
    logic             do_count;

    assign mode_m   = mode_e'(mode);
    assign do_count = (state_q == ST_RUN) && !stop && en;

    mod_step_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_next (
        .count      (count),
        .step       (step),
        .dir        (dir),
        .mode       (mode_m),
        .next_count (next_count),
        .wrap_hit   (wrap_hit),
        .term_hit   (term_hit)
    );

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop is ignored outside RUN, so a start in the same cycle still applies there.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = ST_IDLE;
        end else if (load) begin
            if (state_q == ST_DONE) state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) state_d = ST_RUN;
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (en && (mode_m == MODE_ONESHOT) && term_hit) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: if (start) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (reset) begin
            count_d = RSTC;
        end else if (load) begin
            count_d = (load_val > MAXC) ? MAXC : load_val;
        end else if (do_count) begin
            count_d = next_count;
            wrap_d  = wrap_hit;
        end
        sat_d = !reset && (mode_m == MODE_SAT) && (count_d == (dir ? '0 : MAXC));
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            count <= RSTC;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
            sat   <= sat_d;
        end
    end

endmodule
